// File: rtl/decoder_seq_00xxx00x.sv
// decoder_seq_00xxx00x
// Sequenced decoder for the 00xxx00x opcode group (NOP, EX AF,AF', DJNZ,
// JR e, JR cc,e, LD dd,nn, ADD HL,ss). It latches one opcode and steps its
// own phase counter (xpt). Each phase emits control strobes, and the last
// phase emits done. Phases that read an operand stall on bus_ready. If the
// bus never answers, a wait timeout aborts the instruction.
//
// Ports:
//   clk, reset       clock; synchronous active-high reset
//   op_valid/opcode  opcode offer from the fetch unit
//   op_ready         opcode accepted this cycle (IDLE or done)
//   flag_z, flag_c   condition flags, sampled in the decision phase
//   b_zero           B==0 after decrement (DJNZ xpt2)
//   bus_ready        operand byte valid on the data bus
//   xpt, busy        current phase; instruction in progress
//   rd_operand ..    per-phase datapath strobes (combinational)
//   done             last phase of the instruction
//   illegal, abort   opcode outside the group; bus wait timeout
module decoder_seq_00xxx00x #(
    parameter int unsigned XPT_W    = 5,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned WAIT_W   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [7:0]       opcode,
    input  logic             flag_z,
    input  logic             flag_c,
    input  logic             b_zero,
    input  logic             bus_ready,
    output logic [XPT_W-1:0] xpt,
    output logic             busy,
    output logic             rd_operand,
    output logic [1:0]       reg_sel,
    output logic             write_l,
    output logic             write_h,
    output logic             alu_add16,
    output logic             alu_hi,
    output logic             write_flags,
    output logic             ex_af,
    output logic             b_dec,
    output logic             pc_add_disp,
    output logic             done,
    output logic             illegal,
    output logic             abort
);

    typedef enum logic {IDLE, EXEC} state_t;

    state_t            state_q, state_d;
    logic [XPT_W-1:0]  xpt_q, xpt_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [7:0]        opcode_q, opcode_d;

    // Opcode classes, decoded from the latched opcode
    logic is_nop, is_ex, is_djnz, is_jr, is_jrcc, is_ld, is_add;
    logic cond_true, ph0, ph1;

    assign is_nop  = (opcode_q == 8'h00);
    assign is_ex   = (opcode_q == 8'h08);
    assign is_djnz = (opcode_q == 8'h10);
    assign is_jr   = (opcode_q == 8'h18);
    assign is_jrcc = (opcode_q[7:5] == 3'b001) && (opcode_q[2:0] == 3'b000);
    assign is_ld   = (opcode_q[7:6] == 2'b00) && (opcode_q[3:0] == 4'h1);
    assign is_add  = (opcode_q[7:6] == 2'b00) && (opcode_q[3:0] == 4'h9);

    assign ph0 = (xpt_q == XPT_W'(0));
    assign ph1 = (xpt_q == XPT_W'(1));

    // JR cc condition: opcode[4:3] = NZ, Z, NC, C
    always_comb begin
        cond_true = 1'b0;
        case (opcode_q[4:3])
            2'b00:   cond_true = !flag_z;
            2'b01:   cond_true = flag_z;
            2'b10:   cond_true = !flag_c;
            default: cond_true = flag_c;
        endcase
    end

    // Phase decode, strobes and next state
    always_comb begin
        logic last;
        logic advance;

        rd_operand  = 1'b0;
        write_l     = 1'b0;
        write_h     = 1'b0;
        alu_add16   = 1'b0;
        alu_hi      = 1'b0;
        write_flags = 1'b0;
        ex_af       = 1'b0;
        b_dec       = 1'b0;
        pc_add_disp = 1'b0;
        illegal     = 1'b0;
        abort       = 1'b0;
        last        = 1'b0;
        advance     = 1'b1;
        state_d     = state_q;
        xpt_d       = xpt_q;
        wait_d      = wait_q;
        opcode_d    = opcode_q;

        if (state_q == EXEC) begin
            if (is_nop) begin
                last = 1'b1;
            end else if (is_ex) begin
                ex_af = 1'b1;
                last  = 1'b1;
            end else if (is_djnz) begin
                if (ph0) begin
                    b_dec = 1'b1;
                end else if (ph1) begin
                    rd_operand = 1'b1;
                end else begin
                    pc_add_disp = !b_zero;
                    last        = 1'b1;
                end
            end else if (is_jr || is_jrcc) begin
                if (ph0) begin
                    rd_operand = 1'b1;
                end else begin
                    pc_add_disp = is_jr || cond_true;
                    last        = 1'b1;
                end
            end else if (is_ld) begin
                rd_operand = 1'b1;
                if (ph0) begin
                    write_l = bus_ready;
                end else begin
                    write_h = bus_ready;
                    last    = bus_ready;
                end
            end else if (is_add) begin
                alu_add16 = 1'b1;
                if (ph0) begin
                    write_l = 1'b1;
                end else begin
                    alu_hi      = 1'b1;
                    write_h     = 1'b1;
                    write_flags = 1'b1;
                    last        = 1'b1;
                end
            end else begin
                illegal = 1'b1;
                last    = 1'b1;
            end

            // Operand phases stall on the bus; timeout ends the instruction
            if (rd_operand) begin
                advance = bus_ready;
                if (!bus_ready && (wait_q == WAIT_W'(WAIT_MAX))) begin
                    abort       = 1'b1;
                    write_l     = 1'b0;
                    write_h     = 1'b0;
                    pc_add_disp = 1'b0;
                end
            end
        end

        done     = last || abort;
        op_ready = (state_q == IDLE) || done;

        if (state_q == EXEC) begin
            if (done) begin
                state_d = IDLE;
                xpt_d   = '0;
                wait_d  = '0;
            end else if (advance) begin
                xpt_d  = xpt_q + XPT_W'(1);
                wait_d = '0;
            end else begin
                wait_d = wait_q + WAIT_W'(1);
            end
        end

        if (op_valid && op_ready) begin
            opcode_d = opcode;
            state_d  = EXEC;
            xpt_d    = '0;
            wait_d   = '0;
        end
    end

    assign busy    = (state_q == EXEC);
    assign xpt     = xpt_q;
    assign reg_sel = busy ? opcode_q[5:4] : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            xpt_q    <= '0;
            wait_q   <= '0;
            opcode_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            xpt_q    <= xpt_d;
            wait_q   <= wait_d;
            opcode_q <= opcode_d;
        end
    end

endmodule

// File: doc/decoder_seq_00xxx00x.md
Name: decoder_seq_00xxx00x

Overview:
- Sequenced successor to the combinational 00xxx00x opcode-group decoder.
- Latches one opcode and owns the phase counter (xpt); it no longer takes xpt as an input.
- Steps through the execution phases of NOP, EX AF,AF', DJNZ, JR e, JR cc,e, LD dd,nn and ADD HL,ss, stalling on operand-bus handshakes.
- Emits per-phase control strobes and a done (CM1-equivalent) pulse. Sits between the opcode fetch unit and the register/ALU/PC datapath.

Parameters:
- XPT_W, 5, width of the xpt phase counter; must be >= 2.
- WAIT_MAX, 15, maximum cycles a rd_operand phase may wait for bus_ready before the instruction is aborted; must be >= 1.
- WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > WAIT_MAX.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  opcode offered
- op_ready  out  1  block accepts an opcode this cycle
- opcode  in  8  opcode byte
- flag_z  in  1  Z flag, sampled in the decision phase
- flag_c  in  1  C flag, sampled in the decision phase
- b_zero  in  1  B==0 after decrement, sampled in DJNZ xpt2
- bus_ready  in  1  operand byte valid on the data bus
- xpt  out  XPT_W  current phase
- busy  out  1  instruction in progress
- rd_operand  out  1  operand read request
- reg_sel  out  2  register pair: 0 BC, 1 DE, 2 HL, 3 SP (opcode[5:4])
- write_l  out  1  write low byte of the selected pair (HL for ADD)
- write_h  out  1  write high byte
- alu_add16  out  1  16-bit ADD active
- alu_hi  out  1  ADD high-byte step (carry-in from low)
- write_flags  out  1  update C; clear N; update H from bit 11 carry
- ex_af  out  1  swap AF/AF'
- b_dec  out  1  decrement B
- pc_add_disp  out  1  PC += signed displacement
- done  out  1  last phase of the instruction
- illegal  out  1  opcode outside 00xxx00x
- abort  out  1  bus wait timeout

Behaviour:
Reset and interface
- Reset: state IDLE, xpt=0, wait count=0, latched opcode=0x00; all strobes, done, illegal, abort and busy = 0; op_ready=1. Reset mid-instruction drops the instruction; no further strobes are issued.
- Two states, IDLE and EXEC. op_ready = IDLE | done. An opcode is accepted on op_valid & op_ready: it is latched, the next state is EXEC and the next xpt is 0.
- Back-to-back: acceptance during the done cycle gives zero bubble.
- busy = EXEC.
- Strobes are decoded combinationally from the registered state, xpt, latched opcode and the live flag/bus inputs. Strobes are 0 in IDLE.

Phase tables
Phases with no condition advance unconditionally. Phases containing rd_operand advance only on bus_ready.
- NOP (00): xpt0: done.
- EX AF,AF' (08): xpt0: ex_af, done.
- DJNZ (10): xpt0: b_dec. xpt1: rd_operand. xpt2: done, plus pc_add_disp if !b_zero.
- JR e (18): xpt0: rd_operand. xpt1: pc_add_disp, done.
- JR cc (20 NZ, 28 Z, 30 NC, 38 C): xpt0: rd_operand. xpt1: done, plus pc_add_disp if the condition is true.
- LD dd,nn (x1, bit3=0): xpt0: rd_operand, write_l = bus_ready. xpt1: rd_operand, write_h = bus_ready, done = bus_ready.
- ADD HL,ss (x9): xpt0: alu_add16, write_l (HL). xpt1: alu_add16, alu_hi, write_h, write_flags, done.
- Other opcodes: xpt0: illegal, done; no other strobes.

Wait handling
- The wait counter increments each rd_operand cycle with !bus_ready and clears on phase advance.
- If the counter equals WAIT_MAX while bus_ready=0: abort=1 and done=1 for that cycle, with no write or pc strobes. The block then returns to IDLE, or accepts a new opcode in that cycle.
- bus_ready is ignored outside rd_operand phases.

Phase counter
- xpt increments by 1 on advance (mod 2^XPT_W, never reached in the tables above).
- On done, the next xpt is 0.

Test Plan:
- Reset mid-DJNZ (xpt1): next cycle xpt=0, busy=0, op_ready=1, all strobes 0; no pc_add_disp.
- Back-to-back NOP,NOP,08 with op_valid held: done high three consecutive cycles; ex_af high on the third; op_ready=1 throughout.
- LD DE,nn (0x11) with bus_ready low 3 cycles, then high 2 cycles: reg_sel=1; xpt0 held 4 cycles; write_l on cycle 4; write_h+done on cycle 5.
- JR NZ (0x20) with flag_z=1 → done at xpt1 without pc_add_disp. Repeat with flag_z=0 → pc_add_disp+done.
- DJNZ with b_zero=0 → b_dec at xpt0, pc_add_disp at xpt2. With b_zero=1 → no pc_add_disp; done at xpt2 either way.
- ADD HL,SP (0x39): xpt0 alu_add16+write_l, xpt1 alu_hi+write_h+write_flags+done, reg_sel=3. Opcode 0x02 → illegal+done in 1 cycle. JR e (0x18) with bus_ready held low → abort+done after WAIT_MAX=15 wait cycles, no pc_add_disp.
